// File: rtl/dffram_port_arbiter.sv
// rtl/dffram_port_arbiter.sv - round-robin share of one single-port DFFRAM between Wishbone and the core
//
// Purpose:
//   Two requesters contend for one single-port 256 x 32 DFFRAM macro:
//   - the Caravel management Wishbone slave (wbs_*)
//   - the Ibtida core data port (core_*: req/gnt/rvalid)
//   Each access takes two cycles:
//   - IDLE is the grant cycle, which drives EN0 and the address/data.
//   - RESP returns the macro's Do0 to the owner.
//   Ties alternate against the last winner.
//
// Ports:
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   wbs_cyc_i .. wbs_dat_i     Wishbone slave request (byte address, sel, data)
//   wbs_ack_o, wbs_dat_o       one-cycle ack with read data (0 otherwise)
//   core_req_i .. core_wdata_i core request (byte address, byte enables, data)
//   core_gnt_o                 combinational grant in the grant cycle
//   core_rvalid_o, core_rdata_o response one cycle after grant (data 0 otherwise)
//   ram_en_o, ram_we_o         DFFRAM EN0 / WE0[3:0]
//   ram_addr_o, ram_di_o       DFFRAM word address / Di0
//   ram_do_i                   DFFRAM Do0, valid the cycle after EN0
module dffram_port_arbiter #(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [3:0]        core_be_i,
   input  logic [31:0]       core_addr_i,
   input  logic [31:0]       core_wdata_i,
   output logic              core_gnt_o,
   output logic              core_rvalid_o,
   output logic [31:0]       core_rdata_o,
   output logic              ram_en_o,
   output logic [3:0]        ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_di_o,
   input  logic [31:0]       ram_do_i
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_RESP   = 1'b1;
   localparam logic       OWN_CORE = 1'b0;
   localparam logic       OWN_WBS  = 1'b1;
   localparam int         TAG_LSB  = ADDR_W + 2;

   logic [0:0] state;
   logic       owner;
   logic       last_grant;
   logic       wbs_req;
   logic       grant;
   logic       win_wbs;
   logic       in_resp;

   // Byte-lane bits and address bits above the RAM are not decoded here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{core_addr_i[31:TAG_LSB], core_addr_i[1:0], wbs_adr_i[1:0]};

   // Only accesses inside the Wishbone window count as requests.
   // Others are never acked, so the master's own timeout handles them.
   assign wbs_req = wbs_cyc_i & wbs_stb_i &
                    (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

   // Reset is folded into the grant so every output is 0 while reset is held,
   // even though grant decoding is combinational from the requests.
   assign grant   = wb_rst_ni & (state == S_IDLE) & (wbs_req | core_req_i);

   // On a tie, Wishbone wins unless it won the previous grant.
   assign win_wbs = wbs_req & (~core_req_i | (last_grant == OWN_CORE));
   assign in_resp = (state == S_RESP);

   always_comb begin
      ram_en_o   = 1'b0;
      ram_we_o   = 4'b0;
      ram_addr_o = '0;
      ram_di_o   = 32'b0;
      core_gnt_o = 1'b0;
      if (grant) begin
         ram_en_o = 1'b1;
         if (win_wbs) begin
            ram_we_o   = wbs_we_i ? wbs_sel_i : 4'b0;
            ram_addr_o = wbs_adr_i[ADDR_W+1:2];
            ram_di_o   = wbs_dat_i;
         end else begin
            core_gnt_o = 1'b1;
            ram_we_o   = core_we_i ? core_be_i : 4'b0;
            ram_addr_o = core_addr_i[ADDR_W+1:2];
            ram_di_o   = core_wdata_i;
         end
      end
   end

   // RESP always returns to IDLE, so an aborted Wishbone cycle still gets
   // its ack pulse and the arbiter never stalls waiting on the master.
   assign wbs_ack_o     = in_resp & (owner == OWN_WBS);
   assign core_rvalid_o = in_resp & (owner == OWN_CORE);
   assign wbs_dat_o     = wbs_ack_o     ? ram_do_i : 32'b0;
   assign core_rdata_o  = core_rvalid_o ? ram_do_i : 32'b0;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state      <= S_IDLE;
         owner      <= OWN_CORE;
         last_grant <= OWN_CORE;
      end else if (state == S_IDLE) begin
         if (grant) begin
            state      <= S_RESP;
            owner      <= win_wbs ? OWN_WBS : OWN_CORE;
            last_grant <= win_wbs ? OWN_WBS : OWN_CORE;
         end
      end else begin
         state <= S_IDLE;
      end
   end

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// tb/tb_dffram_port_arbiter.sv - scoreboard bench for dffram_port_arbiter with a behavioural DFFRAM
module tb_dffram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wbs_cyc, wbs_stb, wbs_we;
   logic [3:0]  wbs_sel;
   logic [31:0] wbs_adr, wbs_dat_in;
   logic        wbs_ack;
   logic [31:0] wbs_dat_out;
   logic        core_req, core_we;
   logic [3:0]  core_be;
   logic [31:0] core_addr, core_wdata;
   logic        core_gnt, core_rvalid;
   logic [31:0] core_rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [7:0]  ram_addr;
   logic [31:0] ram_di, ram_do;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] gold [256];
   logic [31:0] exp_q [$];
   logic [31:0] exp_d;
   logic [31:0] mem [256];

   always #5 clk = ~clk;

   dffram_port_arbiter #(.ADDR_W(8), .BASE_ADDR(32'h3000_0000)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we), .wbs_sel_i(wbs_sel),
      .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat_in), .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat_out),
      .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be), .core_addr_i(core_addr),
      .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
      .core_rdata_o(core_rdata), .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
      .ram_di_o(ram_di), .ram_do_i(ram_do)
   );

   // Behavioural single-port DFFRAM: read-before-write, Do0 valid the cycle after EN0.
   always @(posedge clk) begin
      if (ram_en) begin
         ram_do <= mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Backdoor-free preload: a core write that is not itself checked.
   task automatic core_poke(input logic [31:0] addr, input logic [31:0] data);
      core_req = 1'b1; core_we = 1'b1; core_be = 4'hF; core_addr = addr; core_wdata = data;
      gold[addr[9:2]] = data;
      tick;
      core_req = 1'b0; core_we = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      core_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL reset_ram_en got %h want 0", ram_en); end
      vectors++; if (core_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_gnt got %h want 0", core_gnt); end
      vectors++; if (wbs_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %h want 0", wbs_ack); end
      vectors++; if (core_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %h want 0", core_rvalid); end
      vectors++; if (wbs_dat_out !== 32'h0) begin miscompares++; $display("FAIL reset_wbs_dat got %h want 0", wbs_dat_out); end
      vectors++; if (core_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_core_rdata got %h want 0", core_rdata); end
      core_req = 1'b0;
      tick;
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL idle_ram_en got %h want 0", ram_en); end
      vectors++; if (ram_addr !== 8'h0) begin miscompares++; $display("FAIL idle_ram_addr got %h want 0", ram_addr); end
      vectors++; if (ram_di !== 32'h0) begin miscompares++; $display("FAIL idle_ram_di got %h want 0", ram_di); end
      tick;
   endtask

   task automatic test_core_rw;
      core_req = 1'b1; core_we = 1'b1; core_be = 4'hF; core_addr = 32'h0000_0010; core_wdata = 32'hDEADBEEF;
      @(negedge clk);
      vectors++; if (core_gnt !== 1'b1) begin miscompares++; $display("FAIL core_wr_gnt got %h want 1", core_gnt); end
      vectors++; if (ram_addr !== 8'd4) begin miscompares++; $display("FAIL core_wr_addr got %h want 04", ram_addr); end
      vectors++; if (ram_we !== 4'hF) begin miscompares++; $display("FAIL core_wr_we got %h want f", ram_we); end
      vectors++; if (ram_di !== 32'hDEADBEEF) begin miscompares++; $display("FAIL core_wr_di got %h want deadbeef", ram_di); end
      gold[4] = merge(gold[4], 32'hDEADBEEF, 4'hF);
      tick;
      core_req = 1'b0;
      @(negedge clk);
      vectors++; if (core_rvalid !== 1'b1) begin miscompares++; $display("FAIL core_wr_rvalid got %h want 1", core_rvalid); end
      vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL core_resp_en got %h want 0", ram_en); end
      tick;
      core_req = 1'b1; core_we = 1'b0;
      @(negedge clk);
      vectors++; if (core_gnt !== 1'b1) begin miscompares++; $display("FAIL core_rd_gnt got %h want 1", core_gnt); end
      vectors++; if (ram_we !== 4'h0) begin miscompares++; $display("FAIL core_rd_we got %h want 0", ram_we); end
      exp_q.push_back(gold[4]);
      tick;
      core_req = 1'b0;
      @(negedge clk);
      vectors++; if (core_rvalid !== 1'b1) begin miscompares++; $display("FAIL core_rd_rvalid got %h want 1", core_rvalid); end
      exp_d = exp_q.pop_front();
      vectors++; if (core_rdata !== exp_d) begin miscompares++; $display("FAIL core_rd_data got %h want %h", core_rdata, exp_d); end
      tick;
   endtask

   task automatic test_wb_rw;
      core_poke(32'h0000_0020, 32'hAAAAAAAA);
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_sel = 4'b0011;
      wbs_adr = 32'h3000_0020; wbs_dat_in = 32'h12345678;
      @(negedge clk);
      vectors++; if (ram_en !== 1'b1) begin miscompares++; $display("FAIL wb_wr_en got %h want 1", ram_en); end
      vectors++; if (ram_we !== 4'b0011) begin miscompares++; $display("FAIL wb_wr_we got %h want 3", ram_we); end
      vectors++; if (ram_addr !== 8'd8) begin miscompares++; $display("FAIL wb_wr_addr got %h want 08", ram_addr); end
      vectors++; if (wbs_ack !== 1'b0) begin miscompares++; $display("FAIL wb_wr_early_ack got %h want 0", wbs_ack); end
      gold[8] = merge(gold[8], 32'h12345678, 4'b0011);
      tick;
      @(negedge clk);
      vectors++; if (wbs_ack !== 1'b1) begin miscompares++; $display("FAIL wb_wr_ack got %h want 1", wbs_ack); end
      tick;
      wbs_cyc = 1'b0; wbs_stb = 1'b0;
      @(negedge clk);
      vectors++; if (wbs_ack !== 1'b0) begin miscompares++; $display("FAIL wb_wr_single_ack got %h want 0", wbs_ack); end
      tick;
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0;
      @(negedge clk);
      vectors++; if (ram_en !== 1'b1) begin miscompares++; $display("FAIL wb_rd_en got %h want 1", ram_en); end
      vectors++; if (ram_we !== 4'h0) begin miscompares++; $display("FAIL wb_rd_we got %h want 0", ram_we); end
      exp_q.push_back(gold[8]);
      tick;
      @(negedge clk);
      vectors++; if (wbs_ack !== 1'b1) begin miscompares++; $display("FAIL wb_rd_ack got %h want 1", wbs_ack); end
      exp_d = exp_q.pop_front();
      vectors++; if (wbs_dat_out !== exp_d) begin miscompares++; $display("FAIL wb_rd_data got %h want %h", wbs_dat_out, exp_d); end
      vectors++; if (wbs_dat_out !== 32'hAAAA5678) begin miscompares++; $display("FAIL wb_rd_merge got %h want aaaa5678", wbs_dat_out); end
      tick;
      wbs_cyc = 1'b0; wbs_stb = 1'b0;
      @(negedge clk);
      vectors++; if (wbs_ack !== 1'b0) begin miscompares++; $display("FAIL wb_rd_single_ack got %h want 0", wbs_ack); end
      vectors++; if (wbs_dat_out !== 32'h0) begin miscompares++; $display("FAIL wb_idle_dat got %h want 0", wbs_dat_out); end
      tick;
   endtask

   task automatic test_contention;
      core_poke(32'h0000_0004, 32'h11111111);
      core_poke(32'h0000_0008, 32'h22222222);
      rst_n = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0008;
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h3000_0004;
      @(negedge clk);
      vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL rr_reset_en got %h want 0", ram_en); end
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic       e_en, e_gnt, e_ack, e_rv;
         logic [7:0] e_addr;
         e_en   = (i % 2 == 0);
         e_gnt  = (i % 4 == 2);
         e_ack  = (i % 4 == 1);
         e_rv   = (i % 4 == 3);
         e_addr = (i % 4 == 0) ? 8'd1 : 8'd2;
         @(negedge clk);
         vectors++; if (ram_en !== e_en) begin miscompares++; $display("FAIL rr_en[%0d] got %h want %h", i, ram_en, e_en); end
         vectors++; if (core_gnt !== e_gnt) begin miscompares++; $display("FAIL rr_gnt[%0d] got %h want %h", i, core_gnt, e_gnt); end
         vectors++; if (wbs_ack !== e_ack) begin miscompares++; $display("FAIL rr_ack[%0d] got %h want %h", i, wbs_ack, e_ack); end
         vectors++; if (core_rvalid !== e_rv) begin miscompares++; $display("FAIL rr_rvalid[%0d] got %h want %h", i, core_rvalid, e_rv); end
         if (e_en) begin
            vectors++; if (ram_addr !== e_addr) begin miscompares++; $display("FAIL rr_addr[%0d] got %h want %h", i, ram_addr, e_addr); end
            exp_q.push_back(gold[e_addr]);
         end
         if (e_ack) begin
            exp_d = exp_q.pop_front();
            vectors++; if (wbs_dat_out !== exp_d) begin miscompares++; $display("FAIL rr_wb_data[%0d] got %h want %h", i, wbs_dat_out, exp_d); end
         end
         if (e_rv) begin
            exp_d = exp_q.pop_front();
            vectors++; if (core_rdata !== exp_d) begin miscompares++; $display("FAIL rr_core_data[%0d] got %h want %h", i, core_rdata, exp_d); end
         end
         tick;
      end
      core_req = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
      tick;
   endtask

   task automatic test_out_of_window;
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h3000_0400;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0010;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++; if (wbs_ack !== 1'b0) begin miscompares++; $display("FAIL oow_ack[%0d] got %h want 0", i, wbs_ack); end
         vectors++; if (ram_en !== (i == 0)) begin miscompares++; $display("FAIL oow_en[%0d] got %h want %h", i, ram_en, (i == 0)); end
         vectors++; if (core_gnt !== (i == 0)) begin miscompares++; $display("FAIL oow_gnt[%0d] got %h want %h", i, core_gnt, (i == 0)); end
         vectors++; if (core_rvalid !== (i == 1)) begin miscompares++; $display("FAIL oow_rvalid[%0d] got %h want %h", i, core_rvalid, (i == 1)); end
         if (i == 0) exp_q.push_back(gold[4]);
         if (i == 1) begin
            exp_d = exp_q.pop_front();
            vectors++; if (core_rdata !== exp_d) begin miscompares++; $display("FAIL oow_core_data got %h want %h", core_rdata, exp_d); end
         end
         tick;
         if (i == 0) core_req = 1'b0;
      end
      wbs_cyc = 1'b0; wbs_stb = 1'b0;
      tick;
   endtask

   task automatic test_reset_in_resp;
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h3000_0004;
      @(negedge clk);
      vectors++; if (ram_addr !== 8'd1) begin miscompares++; $display("FAIL rst_rd_addr got %h want 01", ram_addr); end
      exp_q.push_back(gold[1]);
      tick;
      vectors++; if (wbs_ack !== 1'b1) begin miscompares++; $display("FAIL rst_pre_ack got %h want 1", wbs_ack); end
      rst_n = 1'b0;
      #1;
      vectors++; if (wbs_ack !== 1'b0) begin miscompares++; $display("FAIL rst_async_ack got %h want 0", wbs_ack); end
      vectors++; if (wbs_dat_out !== 32'h0) begin miscompares++; $display("FAIL rst_async_dat got %h want 0", wbs_dat_out); end
      exp_d = exp_q.pop_front();
      tick;
      rst_n = 1'b1;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0008;
      @(negedge clk);
      vectors++; if (ram_en !== 1'b1) begin miscompares++; $display("FAIL rst_tie_en got %h want 1", ram_en); end
      vectors++; if (core_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_tie_gnt got %h want 0", core_gnt); end
      vectors++; if (ram_addr !== 8'd1) begin miscompares++; $display("FAIL rst_tie_addr got %h want 01", ram_addr); end
      exp_q.push_back(gold[1]);
      tick;
      core_req = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
      @(negedge clk);
      vectors++; if (wbs_ack !== 1'b1) begin miscompares++; $display("FAIL rst_tie_ack got %h want 1", wbs_ack); end
      exp_d = exp_q.pop_front();
      vectors++; if (wbs_dat_out !== exp_d) begin miscompares++; $display("FAIL rst_tie_data got %h want %h", wbs_dat_out, exp_d); end
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_sel = 4'h0;
      wbs_adr = 32'h0; wbs_dat_in = 32'h0;
      core_req = 1'b0; core_we = 1'b0; core_be = 4'h0; core_addr = 32'h0; core_wdata = 32'h0;
      for (int k = 0; k < 256; k++) gold[k] = 32'h0;
      test_reset;
      test_core_rw;
      test_wb_rw;
      test_contention;
      test_out_of_window;
      test_reset_in_resp;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
